wave_voice_bank: RTL
====================

# wave_voice_bank

Parametrised bank of `NUM_CH` independent sample-address generators. It is the multi-channel successor to the single-voice wave address counter. Each voice is fired by a front-panel button or by its sequencer step bit, and then walks a sample-memory address from 0 to its latched depth. Voices support one-shot and loop playback, retrigger, explicit stop and a completion pulse. The block sits between the button/sequencer layer and the per-channel sample ROM read ports; `playing` doubles as the ROM read enable.

## Interface
- `NUM_CH`, default 4: number of voices.
- `ADDR_W`, default 15: width of each voice's depth and address.

Ports (clock and reset first):
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears every voice.
- `trig_btn` in NUM_CH: button trigger level per voice.
- `trig_seq` in NUM_CH: sequencer step-bit trigger level per voice.
- `loop_en` in NUM_CH: 1 = loop at end of sample; 0 = one-shot.
- `stop` in NUM_CH: level; forces the voice idle.
- `depth` in NUM_CH*ADDR_W: per-voice sample length. Voice i uses bits [i*ADDR_W +: ADDR_W].
- `address` out NUM_CH*ADDR_W: per-voice ROM address, packed like `depth`.
- `playing` out NUM_CH: voice active; also the ROM read enable.
- `done` out NUM_CH: one-cycle pulse when a one-shot voice finishes naturally.
- `any_playing` out 1: OR of `playing`.

## Operation
- Per-voice trigger source: `trig = trig_btn | trig_seq`.
  - A register holds the previous value of `trig`.
  - A fire event is `trig & ~trig_prev`, i.e. a rising edge only. Held levels do not refire.
- Per-voice FSM has two states, IDLE and PLAY.
- IDLE:
  - `address = 0`, `playing = 0`.
  - On a fire event with `depth != 0`: latch `depth` into `depth_q`, set `address <= 0`, `playing <= 1`, go to PLAY.
  - A fire event with `depth == 0` is ignored; the voice stays IDLE.
- PLAY, evaluated in priority order:
  1. `stop` asserted: go IDLE, `address <= 0`, no `done`.
  2. Fire event (retrigger): relatch `depth`, `address <= 0`, stay in PLAY. If the new depth is 0, go IDLE with no `done`.
  3. `address == depth_q - 1`:
     - `loop_en = 1`: `address <= 0`, stay in PLAY.
     - Otherwise: go IDLE, `address <= 0`, `done <= 1` for one cycle.
  4. Otherwise: `address <= address + 1`.
- `depth_q` is latched only at fire and retrigger. Changes to `depth` mid-play have no effect until the next fire.
- `loop_en` is sampled live at the end-of-sample cycle.
- Arithmetic is unsigned `ADDR_W`-bit. `depth_q - 1` never underflows because `depth_q != 0` in PLAY.
  - Maximum sample length is 2^ADDR_W − 1 addresses.
- `stop` held in IDLE blocks firing, because stop has priority in every state.
  - `trig_prev` still updates during stop, so releasing stop while the trigger is held does not fire.
- Voices are fully independent. Simultaneous events on different voices are all serviced in the same cycle.

## Timing
- Reset (asynchronous): all FSMs IDLE, `address = 0`, `playing = 0`, `done = 0`, `any_playing = 0`, `trig_prev = 0`, `depth_q = 0`.
  - Assertion mid-play clears outputs immediately, without waiting for a clock edge.
  - After reset deassertion, a trigger that is already high counts as a rising edge at the first clock.
- Fire latency: `trig` is low at edge n−1 and high at edge n. After edge n, `playing = 1` and `address = 0`. After edge n+k, `address = k`.
- A one-shot voice of depth D shows addresses 0..D−1, one per cycle; `playing` is high for exactly D cycles.
  - At the edge after `address = D−1`: `playing` falls and `done` rises for exactly one cycle.
- Loop: after `address = D−1` the next cycle shows `address = 0`, with no gap and no `done`.
- Stop latency: one edge. `playing` falls at the first edge where `stop` is sampled high.
- All outputs are registered except `any_playing`, which is a combinational OR of registered `playing`.

## Structure
- Shared package `wave_pkg`:
  - state enum `voice_state_t {IDLE, PLAY}`;
  - localparam default `ADDR_W = 15`;
  - a function that slices a packed per-channel vector.
- Sub-module `wave_voice`: one voice, containing the FSM, edge detect, `depth_q`, address counter and `done` logic.
  - `wave_voice_bank` is a generate loop of `NUM_CH` instances plus the `any_playing` OR.

## Test plan
- **Reset:** drive `reset` high mid-play on voice 0 at `address = 2`, between clock edges. Expect `address = 0` and `playing = 0` immediately, and `done` never pulses.
- **One-shot:** depth0 = 4, `loop_en = 0`, pulse `trig_btn[0]`.
  - Expect addresses 0,1,2,3 on consecutive cycles with `playing` high for 4 cycles.
  - Then `done[0]` for 1 cycle, then `address = 0`.
- **Loop and stop:** depth1 = 3, `loop_en[1] = 1`, pulse `trig_seq[1]`.
  - Expect 0,1,2,0,1,2 and no `done`.
  - Assert `stop[1]` at `address = 1`: next cycle `playing = 0`, `address = 0`.
- **Retrigger and depth latch:** depth2 = 8, fire.
  - At `address = 5`, change depth2 to 2; the count still runs 6,7.
  - Fire again at `address = 7`: next cycle `address = 0`, and the new depth 2 governs the run.
- **Edge and zero-depth rules:**
  - Hold `trig_btn[3]` high for 20 cycles with depth3 = 4: exactly one play and one `done`.
  - Fire with depth3 = 0: `playing[3]` stays 0.
- **Simultaneity:** fire all four voices with depths 1,2,3,4.
  - `done` pulses on cycles 1,2,3,4 after the fire.
  - `any_playing` is high for exactly 4 cycles.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and helpers for the multi-voice wave sample-address generator.
package wave_pkg;

    typedef enum logic {IDLE, PLAY} voice_state_t;

    localparam int unsigned DEFAULT_ADDR_W = 15;
    localparam int unsigned MaxVecW        = 1024;
    localparam int unsigned MaxSliceW      = 32;

    // Extract channel `ch` of width `w` from a packed per-channel vector.
    function automatic logic [MaxSliceW-1:0] slice_ch(input logic [MaxVecW-1:0] vec,
                                                      input int unsigned ch,
                                                      input int unsigned w);
        logic [MaxSliceW-1:0] mask;
        mask = (MaxSliceW'(1) << w) - MaxSliceW'(1);
        return MaxSliceW'(vec >> (ch * w)) & mask;
    endfunction

endpackage

// File: rtl/wave_voice.sv
// One sample-address voice: trigger edge detect, depth latch, address counter and done pulse.
module wave_voice import wave_pkg::*; #(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trig_i,
    input  logic              loop_en_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] depth_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              playing_o,
    output logic              done_o
);

    voice_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] depth_q, depth_d;
    logic              trig_prev_q;
    logic              done_q, done_d;
    logic              fire;

    assign fire = trig_i & ~trig_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            depth_q     <= '0;
            trig_prev_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            depth_q     <= depth_d;
            trig_prev_q <= trig_i;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Stop outranks fire even while idle; zero-depth fires are dropped.
                if (!stop_i && fire && depth_i != '0) begin
                    depth_d = depth_i;
                    addr_d  = '0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (stop_i) begin
                    addr_d  = '0;
                    state_d = IDLE;
                end else if (fire) begin
                    depth_d = depth_i;
                    addr_d  = '0;
                    if (depth_i == '0) state_d = IDLE;
                end else if (addr_q == depth_q - ADDR_W'(1)) begin
                    addr_d = '0;
                    if (!loop_en_i) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                addr_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign address_o = addr_q;
    assign playing_o = (state_q == PLAY);
    assign done_o    = done_q;

endmodule

// File: rtl/wave_voice_bank.sv
// Bank of NUM_CH independent wave voices feeding per-channel sample ROM read ports.
module wave_voice_bank import wave_pkg::*; #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        trig_btn,
    input  logic [NUM_CH-1:0]        trig_seq,
    input  logic [NUM_CH-1:0]        loop_en,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH*ADDR_W-1:0] depth,
    output logic [NUM_CH*ADDR_W-1:0] address,
    output logic [NUM_CH-1:0]        playing,
    output logic [NUM_CH-1:0]        done,
    output logic                     any_playing
);

    logic [NUM_CH-1:0] trig;

    assign trig = trig_btn | trig_seq;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        logic [ADDR_W-1:0] depth_v;

        assign depth_v = ADDR_W'(slice_ch(MaxVecW'(depth), i, ADDR_W));

        wave_voice #(
            .ADDR_W(ADDR_W)
        ) u_voice (
            .clock     (clock),
            .reset     (reset),
            .trig_i    (trig[i]),
            .loop_en_i (loop_en[i]),
            .stop_i    (stop[i]),
            .depth_i   (depth_v),
            .address_o (address[i*ADDR_W +: ADDR_W]),
            .playing_o (playing[i]),
            .done_o    (done[i])
        );
    end

    assign any_playing = |playing;

endmodule
